noc_port_arbiter: RTL

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

---
 rtl/noc_port_arbiter_if.sv | 28 ++
 rtl/noc_port_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/noc_port_arbiter_if.sv
// rtl/noc_port_arbiter_if.sv - N-to-1 flit arbiter bus: per-port inputs plus shared output.
interface noc_port_arbiter_if #(
  parameter int N   = 4,
  parameter int D_W = 32,
  parameter int A_W = 32
);
  localparam int W = A_W + D_W + 1;
  localparam int S = $clog2(N);

  logic [N-1:0]   i_v;
  logic [N*W-1:0] i_d;
  logic [N-1:0]   i_b;
  logic           o_v;
  logic [W-1:0]   o_d;
  logic           o_b;
  logic [S-1:0]   o_sel;
  logic           o_lock;

  modport master (
    input  i_v, i_d, o_b,
    output i_b, o_v, o_d, o_sel, o_lock
  );

  modport slave (
    output i_v, i_d, o_b,
    input  i_b, o_v, o_d, o_sel, o_lock
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// rtl/noc_port_arbiter.sv - round-robin packet arbiter; locks a port from first flit to last.
module noc_port_arbiter #(
  parameter int N   = 4,
  parameter int D_W = 32,
  parameter int A_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_port_arbiter_if.master    bus
);
  localparam int W = A_W + D_W + 1;
  localparam int S = $clog2(N);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state;
  logic [S-1:0]   gnt;
  logic [S-1:0]   ptr;

  logic           found;
  logic [S-1:0]   sel;
  logic [S-1:0]   cand;
  logic [S-1:0]   cur;
  logic [W-1:0]   cur_flit;
  logic [N-1:0]   cur_mask;
  logic           xfer;
  logic           last;

  function automatic logic [S-1:0] inc_mod(input logic [S-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + 1'b1;
  endfunction

  // Cyclic priority search starting at ptr; first hit wins.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = ptr;
    for (int i = 0; i < N; i++) begin
      cand = S'(int'(ptr) + i - ((int'(ptr) + i >= N) ? N : 0));
      if (!found && bus.i_v[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    cur      = (state == LOCKED) ? gnt : sel;
    cur_flit = '0;
    cur_mask = '0;
    for (int k = 0; k < N; k++) begin
      if (cur == S'(k)) begin
        cur_flit    = bus.i_d[k*W +: W];
        cur_mask[k] = 1'b1;
      end
    end
  end

  // Reset overrides everything combinationally; non-selected ports are always held off.
  always_comb begin
    bus.o_v    = 1'b0;
    bus.o_d    = '0;
    bus.o_sel  = '0;
    bus.i_b    = '1;
    bus.o_lock = 1'b0;
    if (!rst) begin
      bus.o_lock = (state == LOCKED);
      if (state == LOCKED) begin
        bus.o_sel = gnt;
        bus.o_v   = bus.i_v[gnt];
        bus.o_d   = cur_flit;
        bus.i_b   = ~cur_mask | {N{bus.o_b}};
      end else if (found) begin
        bus.o_sel = sel;
        bus.o_v   = 1'b1;
        bus.o_d   = cur_flit;
        bus.i_b   = ~cur_mask | {N{bus.o_b}};
      end else begin
        bus.o_sel = ptr;
      end
    end
  end

  assign xfer = bus.o_v & ~bus.o_b;
  assign last = cur_flit[W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            if (xfer && last) begin
              ptr <= inc_mod(sel);
            end else begin
              state <= LOCKED;
              gnt   <= sel;
            end
          end
        end
        LOCKED: begin
          if (xfer && last) begin
            state <= IDLE;
            ptr   <= inc_mod(gnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
